// File: rtl/alu_ctrl_pipe_if.sv
// rtl/alu_ctrl_pipe_if.sv - decode-to-execute handshake bundle for the ALU control unit
interface alu_ctrl_pipe_if #(
  parameter int OPW   = 11,
  parameter int CTRLW = 3
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   instruct;
  logic [1:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [CTRLW-1:0] alu_ctrl;
  logic [1:0]       ext_op;
  logic             illegal;
  logic             busy;

  modport master (
    output flush, in_valid, instruct, alu_op, out_ready,
    input  in_ready, out_valid, alu_ctrl, ext_op, illegal, busy
  );

  modport slave (
    input  flush, in_valid, instruct, alu_op, out_ready,
    output in_ready, out_valid, alu_ctrl, ext_op, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// rtl/alu_ctrl_pipe.sv - registered, handshaked LEGv8 ALU control with extended-op latency hold
module alu_ctrl_pipe #(
  parameter int OPW       = 11,
  parameter int CTRLW     = 3,
  parameter int SHIFT_LAT = 1,
  parameter int MUL_LAT   = 4
) (
  input logic            clk,
  input logic            reset,
  alu_ctrl_pipe_if.slave bus
);
  localparam int MAX_LAT = (SHIFT_LAT > MUL_LAT) ? SHIFT_LAT : MUL_LAT;
  localparam int CNTW    = $clog2(MAX_LAT + 1);

  localparam logic [2:0] C_PASSB = 3'b000;
  localparam logic [2:0] C_ADD   = 3'b010;
  localparam logic [2:0] C_SUB   = 3'b011;
  localparam logic [2:0] C_AND   = 3'b100;
  localparam logic [2:0] C_OR    = 3'b101;
  localparam logic [2:0] C_XOR   = 3'b110;

  localparam logic [1:0] X_NONE = 2'b00;
  localparam logic [1:0] X_LSL  = 2'b01;
  localparam logic [1:0] X_LSR  = 2'b10;
  localparam logic [1:0] X_MUL  = 2'b11;

  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [2:0]       ctrl_q;
  logic [1:0]       ext_q;
  logic             ill_q;
  logic             valid_q;
  logic             busy_q;

  logic [10:0]      f;
  logic [2:0]       dec_ctrl;
  logic [1:0]       dec_ext;
  logic             dec_ill;
  logic             accept;
  logic [CTRLW-1:0] ctrl_word;

  assign f = bus.instruct[OPW-1:OPW-11];

  always_comb begin
    dec_ctrl = C_ADD;
    dec_ext  = X_NONE;
    dec_ill  = 1'b0;
    case (bus.alu_op)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_PASSB;
      2'b10: begin
        case (f)
          OP_ADDS: dec_ctrl = C_ADD;
          OP_SUBS: dec_ctrl = C_SUB;
          OP_AND:  dec_ctrl = C_AND;
          OP_ORR:  dec_ctrl = C_OR;
          OP_EOR:  dec_ctrl = C_XOR;
          OP_LSL: begin
            dec_ctrl = C_PASSB;
            dec_ext  = X_LSL;
          end
          OP_LSR: begin
            dec_ctrl = C_PASSB;
            dec_ext  = X_LSR;
          end
          OP_MUL: begin
            dec_ctrl = C_PASSB;
            dec_ext  = X_MUL;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
        case (f[10:1])
          OP_ADDI: dec_ctrl = C_ADD;
          OP_SUBI: dec_ctrl = C_SUB;
          default: dec_ill  = 1'b1;
        endcase
      end
    endcase
  end

  assign bus.in_ready = !reset && !bus.flush &&
                        (state == S_IDLE || (state == S_HOLD && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ctrl_q  <= '0;
      ext_q   <= X_NONE;
      ill_q   <= 1'b0;
    end else if (bus.flush) begin
      // Decoded fields survive a flush; only the handshake state is killed.
      state   <= S_IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_BUSY: begin
          if (cnt == CNTW'(1)) begin
            state   <= S_HOLD;
            cnt     <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      // accept is only possible from IDLE or a draining HOLD, so it overrides the above.
      if (accept) begin
        ctrl_q <= dec_ctrl;
        ext_q  <= dec_ext;
        ill_q  <= dec_ill;
        if (dec_ext != X_NONE) begin
          state   <= S_BUSY;
          cnt     <= (dec_ext == X_MUL) ? CNTW'(MUL_LAT) : CNTW'(SHIFT_LAT);
          valid_q <= 1'b0;
          busy_q  <= 1'b1;
        end else begin
          state   <= S_HOLD;
          cnt     <= '0;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ctrl_word      = '0;
    ctrl_word[2:0] = ctrl_q;
  end

  assign bus.alu_ctrl  = ctrl_word;
  assign bus.ext_op    = ext_q;
  assign bus.illegal   = ill_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
endmodule
